pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_frame_timer.sv | 41 ++++
 rtl/pwm_fade_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade controller and its frame timer:
// state encoding, default widths and a counter-width helper.
package pwm_pkg;

  localparam int DW_DEFAULT     = 32;
  localparam int PERIOD_DEFAULT = 500000;
  localparam int HOLD_W         = 16;
  localparam int CYCLES_W       = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    RISE = 3'd2,
    FALL = 3'd3,
    DONE = 3'd4
  } fade_state_e;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running PWM frame counter. It counts 0..PERIOD-1 and wraps in every
// state, flagging the last clock of a frame (tick) and the first (sync).
// The PWM generator can instantiate the same block so both stay aligned.
module pwm_frame_timer
  import pwm_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  output logic frame_tick_o,
  output logic frame_sync_o
);

  localparam int            CW   = cntWidth(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] frameCnt_q;
  logic [CW-1:0] frameCnt_d;

  // Advance the count, returning to zero after the last clock of the frame.
  always_comb begin
    frameCnt_d = frameCnt_q + CW'(1);
    if (frameCnt_q == LAST) begin
      frameCnt_d = '0;
    end
  end

  // Counter register; reset parks it at the frame start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frameCnt_q <= '0;
    end else begin
      frameCnt_q <= frameCnt_d;
    end
  end

  assign frame_tick_o = (frameCnt_q == LAST);
  assign frame_sync_o = (frameCnt_q == '0);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade controller: ramps the PWM duty between a programmed minimum and
// maximum in steps, holding each value for a number of frames, for a
// programmed number of rise/fall cycles (or forever). Duty only changes
// on the last clock of a frame so each value covers whole frames.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEFAULT,
  parameter int DW     = DW_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [DW-1:0]       cfg_min_i,
  input  logic [DW-1:0]       cfg_max_i,
  input  logic [DW-1:0]       cfg_step_i,
  input  logic [HOLD_W-1:0]   cfg_hold_i,
  input  logic [CYCLES_W-1:0] cfg_cycles_i,
  output logic [DW-1:0]       duty_o,
  output logic                frame_sync_o,
  output logic                busy_o,
  output logic                done_o
);

  fade_state_e         state_q,    state_d;
  logic [DW-1:0]       duty_q,     duty_d;
  logic [DW-1:0]       min_q,      min_d;
  logic [DW-1:0]       max_q,      max_d;
  logic [DW-1:0]       step_q,     step_d;
  logic [HOLD_W-1:0]   hold_q,     hold_d;
  logic [HOLD_W-1:0]   holdCnt_q,  holdCnt_d;
  logic [CYCLES_W-1:0] cycles_q,   cycles_d;
  logic [CYCLES_W-1:0] cycleCnt_q, cycleCnt_d;
  logic                stopPend_q, stopPend_d;

  logic                frameTick;
  logic                stepEvent;
  logic                stopNow;
  logic [DW:0]         riseSum;
  logic [DW:0]         fallFloor;
  logic [CYCLES_W-1:0] cycleNext;

  pwm_frame_timer #(
    .PERIOD (PERIOD)
  ) u_frame_timer (
    .clk          (clk),
    .resetn       (resetn),
    .frame_tick_o (frameTick),
    .frame_sync_o (frame_sync_o)
  );

  // Sums are one bit wider than duty so the bound checks can never wrap.
  assign riseSum   = {1'b0, duty_q} + {1'b0, step_q};
  assign fallFloor = {1'b0, min_q} + {1'b0, step_q};
  assign stepEvent = frameTick && (holdCnt_q == hold_q - HOLD_W'(1));
  assign stopNow   = frameTick && (stopPend_q || stop_i);
  assign cycleNext = (cycleCnt_q == '1) ? cycleCnt_q : cycleCnt_q + CYCLES_W'(1);

  // Next-state logic: config latching, ramp stepping and stop handling.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    min_d      = min_q;
    max_d      = max_q;
    step_d     = step_q;
    hold_d     = hold_q;
    holdCnt_d  = holdCnt_q;
    cycles_d   = cycles_q;
    cycleCnt_d = cycleCnt_q;
    stopPend_d = stopPend_q;

    if ((state_q != IDLE) && stop_i) begin
      stopPend_d = 1'b1;
    end

    if ((state_q != IDLE) && stopNow) begin
      duty_d     = '0;
      stopPend_d = 1'b0;
      state_d    = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            min_d      = cfg_min_i;
            max_d      = (cfg_min_i > cfg_max_i) ? cfg_min_i : cfg_max_i;
            step_d     = (cfg_step_i == '0) ? DW'(1) : cfg_step_i;
            hold_d     = (cfg_hold_i == '0) ? HOLD_W'(1) : cfg_hold_i;
            cycles_d   = cfg_cycles_i;
            stopPend_d = 1'b0;
            state_d    = ARM;
          end
        end
        ARM: begin
          if (frameTick) begin
            duty_d     = min_q;
            holdCnt_d  = '0;
            cycleCnt_d = '0;
            state_d    = RISE;
          end
        end
        RISE: begin
          if (stepEvent) begin
            holdCnt_d = '0;
            if (riseSum >= {1'b0, max_q}) begin
              duty_d  = max_q;
              state_d = FALL;
            end else begin
              duty_d = riseSum[DW-1:0];
            end
          end else if (frameTick) begin
            holdCnt_d = holdCnt_q + HOLD_W'(1);
          end
        end
        FALL: begin
          if (stepEvent) begin
            holdCnt_d = '0;
            if ({1'b0, duty_q} < fallFloor) begin
              duty_d     = min_q;
              cycleCnt_d = cycleNext;
              if ((cycles_q != '0) && (cycleNext == cycles_q)) begin
                state_d = DONE;
              end else begin
                state_d = RISE;
              end
            end else begin
              duty_d = duty_q - step_q;
            end
          end else if (frameTick) begin
            holdCnt_d = holdCnt_q + HOLD_W'(1);
          end
        end
        DONE: begin
          stopPend_d = 1'b0;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset aborts any sequence at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      min_q      <= '0;
      max_q      <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      holdCnt_q  <= '0;
      cycles_q   <= '0;
      cycleCnt_q <= '0;
      stopPend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      min_q      <= min_d;
      max_q      <= max_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      holdCnt_q  <= holdCnt_d;
      cycles_q   <= cycles_d;
      cycleCnt_q <= cycleCnt_d;
      stopPend_q <= stopPend_d;
    end
  end

  assign duty_o = duty_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl with a short frame. Expected duty
// per frame comes from a triangle-wave model built out of ramp lists.
module tb_pwm_fade_ctrl;

  localparam int PERIOD = 10;
  localparam int DW     = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start_i;
  logic          stop_i;
  logic [DW-1:0] cfg_min_i;
  logic [DW-1:0] cfg_max_i;
  logic [DW-1:0] cfg_step_i;
  logic [15:0]   cfg_hold_i;
  logic [7:0]    cfg_cycles_i;
  logic [DW-1:0] duty_o;
  logic          frame_sync_o;
  logic          busy_o;
  logic          done_o;

  int     checks   = 0;
  int     failures = 0;
  longint expSeq[$];

  pwm_fade_ctrl #(
    .PERIOD (PERIOD),
    .DW     (DW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .cfg_min_i    (cfg_min_i),
    .cfg_max_i    (cfg_max_i),
    .cfg_step_i   (cfg_step_i),
    .cfg_hold_i   (cfg_hold_i),
    .cfg_cycles_i (cfg_cycles_i),
    .duty_o       (duty_o),
    .frame_sync_o (frame_sync_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog observed=still_running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Per-step duty values: min, then per cycle a rising ramp capped at max
  // followed by a falling ramp floored at min.
  function automatic void buildSeq(input longint mn, input longint mx, input longint st,
                                   input int cyc, input int maxLen);
    longint top;
    longint k;
    int     nDone;
    top = (mn > mx) ? mn : mx;
    if (st == 0) st = 1;
    expSeq.delete();
    expSeq.push_back(mn);
    nDone = 0;
    while ((cyc == 0 && expSeq.size() < maxLen) || (cyc != 0 && nDone < cyc)) begin
      for (k = 1; mn + k * st < top; k++) expSeq.push_back(mn + k * st);
      expSeq.push_back(top);
      for (k = 1; top - k * st >= mn; k++) expSeq.push_back(top - k * st);
      expSeq.push_back(mn);
      nDone++;
    end
  endfunction

  // Wait for a frame start, then start a sequence at a random frame offset.
  task automatic applyStimulus(input logic [DW-1:0] mn, input logic [DW-1:0] mx,
                               input logic [DW-1:0] st, input logic [15:0] hd,
                               input logic [7:0] cy);
    bit found;
    int r;
    found = 0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      @(negedge clk);
      if (frame_sync_o) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL start_align observed=no_frame_sync required=frame_sync");
    end
    r = int'($urandom_range(0, PERIOD - 2));
    repeat (r) @(negedge clk);
    cfg_min_i    = mn;
    cfg_max_i    = mx;
    cfg_step_i   = st;
    cfg_hold_i   = hd;
    cfg_cycles_i = cy;
    start_i      = 1'b1;
    @(negedge clk);
    start_i      = 1'b0;
    cfg_min_i    = $urandom;
    cfg_max_i    = $urandom;
    cfg_step_i   = $urandom;
    cfg_hold_i   = 16'($urandom);
    cfg_cycles_i = 8'($urandom);
  endtask

  // Follow a started sequence cycle by cycle against expSeq, optionally
  // pulsing stop and scrambling cfg/start while the controller is busy.
  task automatic runSequence(input string tag, input int holdEff, input bit finite,
                             input int maxFrames, input int stopFrame, input int stopCyc,
                             input bit scramble);
    int            lastIdx;
    int            doneFrame;
    int            endFrame;
    int            idx;
    bit            found;
    logic [DW-1:0] expDuty;
    logic          expBusy;
    logic          expDone;
    lastIdx   = expSeq.size() - 1;
    doneFrame = finite ? lastIdx * holdEff : -1;
    if (stopFrame >= 0)  endFrame = stopFrame + 1;
    else if (finite)     endFrame = doneFrame;
    else                 endFrame = maxFrames - 1;
    found = 0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      @(negedge clk);
      if (frame_sync_o) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL %s first_frame observed=no_frame_sync required=frame_sync", tag);
      return;
    end
    for (int f = 0; f <= endFrame; f++) begin
      for (int c = 0; c < PERIOD; c++) begin
        if (stopFrame >= 0 && f > stopFrame) begin
          expDuty = '0;
          expBusy = 1'b0;
          expDone = 1'b0;
        end else begin
          idx = f / holdEff;
          if (idx > lastIdx) idx = lastIdx;
          expDuty = DW'(expSeq[idx]);
          if (finite) begin
            expDone = (f == doneFrame) && (c == 0);
            expBusy = (f < doneFrame) || ((f == doneFrame) && (c == 0));
          end else begin
            expDone = 1'b0;
            expBusy = 1'b1;
          end
        end
        checks++;
        if (duty_o !== expDuty) begin
          failures++;
          $display("[TB] FAIL %s duty f=%0d c=%0d observed=%0h required=%0h", tag, f, c, duty_o, expDuty);
        end
        checks++;
        if (busy_o !== expBusy) begin
          failures++;
          $display("[TB] FAIL %s busy f=%0d c=%0d observed=%b required=%b", tag, f, c, busy_o, expBusy);
        end
        checks++;
        if (done_o !== expDone) begin
          failures++;
          $display("[TB] FAIL %s done f=%0d c=%0d observed=%b required=%b", tag, f, c, done_o, expDone);
        end
        checks++;
        if (frame_sync_o !== (c == 0)) begin
          failures++;
          $display("[TB] FAIL %s frame_sync f=%0d c=%0d observed=%b required=%b", tag, f, c, frame_sync_o, (c == 0));
        end
        start_i = 1'b0;
        stop_i  = 1'b0;
        if (stopFrame >= 0 && f == stopFrame && c == stopCyc) stop_i = 1'b1;
        if (scramble && (!finite || f < doneFrame) && (stopFrame < 0 || f < stopFrame)) begin
          start_i      = ($urandom_range(0, 15) == 0);
          cfg_min_i    = $urandom;
          cfg_max_i    = $urandom;
          cfg_step_i   = $urandom;
          cfg_hold_i   = 16'($urandom);
          cfg_cycles_i = 8'($urandom);
        end
        if (!(f == endFrame && c == PERIOD - 1)) @(negedge clk);
      end
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  // Outputs held at their reset values, frame_sync high right after release.
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (duty_o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_duty observed=%0h required=0", duty_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy observed=%b required=0", busy_o);
    end
    checks++;
    if (done_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_done observed=%b required=0", done_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (frame_sync_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_sync observed=%b required=1", frame_sync_o);
    end
    @(negedge clk);
    checks++;
    if (frame_sync_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_second_cycle_sync observed=%b required=0", frame_sync_o);
    end
  endtask

  task automatic test_basic_ramp();
    buildSeq(2, 8, 3, 1, 0);
    applyStimulus(32'd2, 32'd8, 32'd3, 16'd1, 8'd1);
    runSequence("basic_ramp", 1, 1'b1, 0, -1, 0, 1'b0);
  endtask

  task automatic test_inverted_bounds();
    buildSeq(6, 3, 1, 1, 0);
    applyStimulus(32'd6, 32'd3, 32'd1, 16'd1, 8'd1);
    runSequence("inverted_bounds", 1, 1'b1, 0, -1, 0, 1'b1);
  endtask

  task automatic test_no_wrap();
    buildSeq(64'hFFFF_FFF0, 64'hFFFF_FFFF, 64'h20, 1, 0);
    applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 8'd1);
    runSequence("no_wrap", 1, 1'b1, 0, -1, 0, 1'b0);
  endtask

  // Stop mid-rise in counter cycle 3, plus a zero step treated as one.
  task automatic test_stop();
    buildSeq(0, 100, 5, 0, 40);
    applyStimulus(32'd0, 32'd100, 32'd5, 16'd1, 8'd0);
    runSequence("stop_rise", 1, 1'b0, 0, 2, 3, 1'b0);
    buildSeq(3, 9, 0, 0, 40);
    applyStimulus(32'd3, 32'd9, 32'd0, 16'd0, 8'd0);
    runSequence("stop_step0", 1, 1'b0, 0, 9, int'($urandom_range(1, PERIOD - 2)), 1'b0);
  endtask

  // Hold of two frames, endless cycles, with start pulses while busy.
  task automatic test_hold_restart();
    buildSeq(4, 20, 4, 0, 60);
    applyStimulus(32'd4, 32'd20, 32'd4, 16'd2, 8'd0);
    runSequence("hold_restart", 2, 1'b0, 0, 40, int'($urandom_range(1, PERIOD - 2)), 1'b1);
  endtask

  // start+stop together in IDLE is ignored; a lone stop in IDLE is not kept.
  task automatic test_idle_start_stop();
    @(negedge clk);
    cfg_min_i    = 32'd1;
    cfg_max_i    = 32'd5;
    cfg_step_i   = 32'd2;
    cfg_hold_i   = 16'd1;
    cfg_cycles_i = 8'd1;
    start_i      = 1'b1;
    stop_i       = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      checks++;
      if (busy_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_start_stop busy i=%0d observed=%b required=0", i, busy_o);
      end
      @(negedge clk);
    end
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    buildSeq(1, 5, 2, 1, 0);
    applyStimulus(32'd1, 32'd5, 32'd2, 16'd1, 8'd1);
    runSequence("idle_stop_ignored", 1, 1'b1, 0, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
    logic [DW-1:0] st;
    logic [15:0]   hd;
    logic [7:0]    cy;
    int            holdEff;
    int            doneFrame;
    int            stopFrame;
    int            stopCyc;
    for (int n = 0; n < 6; n++) begin
      mn = DW'($urandom_range(0, 15));
      mx = DW'($urandom_range(0, 30));
      st = DW'($urandom_range(0, 6));
      hd = 16'($urandom_range(0, 2));
      cy = 8'($urandom_range(1, 2));
      buildSeq(longint'(mn), longint'(mx), longint'(st), int'(cy), 0);
      holdEff   = (hd == 16'd0) ? 1 : int'(hd);
      doneFrame = (expSeq.size() - 1) * holdEff;
      stopFrame = -1;
      stopCyc   = 0;
      if ($urandom_range(0, 2) == 0) begin
        stopFrame = int'($urandom_range(0, doneFrame - 1));
        stopCyc   = int'($urandom_range(1, PERIOD - 2));
      end
      applyStimulus(mn, mx, st, hd, cy);
      runSequence($sformatf("random%0d", n), holdEff, 1'b1, 0, stopFrame, stopCyc, 1'b1);
    end
  endtask

  // Asynchronous reset in the middle of a running sequence.
  task automatic test_reset_mid();
    applyStimulus(32'd10, 32'd200, 32'd3, 16'd1, 8'd0);
    repeat (25) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_running busy observed=%b required=1", busy_o);
    end
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (duty_o !== '0 || busy_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_async duty=%0h busy=%b required duty=0 busy=0", duty_o, busy_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (duty_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_edge duty=%0h busy=%b done=%b required 0/0/0", duty_o, busy_o, done_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (frame_sync_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_release_sync observed=%b required=1", frame_sync_o);
    end
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || duty_o !== '0) begin
        failures++;
        $display("[TB] FAIL reset_mid_aborted i=%0d busy=%b duty=%0h required busy=0 duty=0", i, busy_o, duty_o);
      end
    end
  endtask

  initial begin
    resetn       = 1'b0;
    start_i      = 1'b0;
    stop_i       = 1'b0;
    cfg_min_i    = '0;
    cfg_max_i    = '0;
    cfg_step_i   = '0;
    cfg_hold_i   = '0;
    cfg_cycles_i = '0;
    test_reset();
    test_basic_ramp();
    test_inverted_bounds();
    test_no_wrap();
    test_stop();
    test_hold_restart();
    test_idle_start_stop();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
